decode_scoreboard: RTL and testbench

Parametrised per-register hazard scoreboard for the decode stage. It replaces the blanket rule "stall while execute holds a division, carry multiply, carry bit-manip or CSR write" with per-destination busy tracking. Decode can then keep issuing independent instructions behind a long-latency operation. The block sits beside the forwarding unit: decode presents the decoded instruction's register usage, and the block returns a combinational stall plus registered busy state.

---
 rtl/decode_scoreboard.sv | 111 +++++++++++
 tb/tb_decode_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_scoreboard.sv
// Per-register hazard scoreboard for decode: tracks busy destinations of
// multi-cycle operations and raises a combinational stall on dependent issue.
module decode_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned IDX_W  = $clog2(NREG),
  parameter int unsigned LAT_W  = 4,
  parameter int unsigned MAXOUT = 4,
  parameter int unsigned CNT_W  = $clog2(MAXOUT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic             rden1,
  input  logic [IDX_W-1:0] raddr1,
  input  logic             rden2,
  input  logic [IDX_W-1:0] raddr2,
  input  logic             wren,
  input  logic [IDX_W-1:0] waddr,
  input  logic             multi,
  input  logic [LAT_W-1:0] latency,
  input  logic             clear,
  input  logic             cmp_valid,
  input  logic [IDX_W-1:0] cmp_waddr,
  output logic             stall,
  output logic [NREG-1:0]  busy,
  output logic [CNT_W-1:0] pending,
  output logic             error
);

  logic [NREG-1:0]  busy_q, var_q, busy_d, var_d;
  logic [NREG-1:0]  rel, busy_eff;
  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] pending_q, pending_d, rel_cnt, pending_eff;
  logic             error_q, error_d;
  logic             hz1, hz2, waw, cap, issue, cmp_bad, stray;

  // A register frees in the same cycle its result reaches the forwarding path.
  always_comb begin
    rel     = '0;
    rel_cnt = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      rel[i]  = busy_q[i] &
                ((var_q[i] & cmp_valid & (cmp_waddr == IDX_W'(i))) |
                 (!var_q[i] & (cnt_q[i] == LAT_W'(1))));
      rel_cnt = rel_cnt + CNT_W'(rel[i]);
    end
  end

  always_comb begin
    busy_eff    = busy_q & ~rel;
    pending_eff = pending_q - rel_cnt;
    hz1   = rden1 & (raddr1 != '0) & busy_eff[raddr1];
    hz2   = rden2 & (raddr2 != '0) & busy_eff[raddr2];
    waw   = wren & (waddr != '0) & busy_eff[waddr];
    cap   = multi & wren & (waddr != '0) & (pending_eff == CNT_W'(MAXOUT));
    stall = reset & valid & (hz1 | hz2 | waw | cap);
    issue = valid & multi & wren & (waddr != '0) & !stall & !clear;
  end

  always_comb begin
    busy_d    = busy_q;
    var_d     = var_q;
    cnt_d     = cnt_q;
    pending_d = '0;
    stray     = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (issue && (waddr == IDX_W'(i))) begin
        busy_d[i] = 1'b1;
        var_d[i]  = (latency == '0);
        cnt_d[i]  = latency;
      end else if (rel[i]) begin
        busy_d[i] = 1'b0;
        var_d[i]  = 1'b0;
        cnt_d[i]  = '0;
      end else if (busy_q[i] && !var_q[i] && (cnt_q[i] > LAT_W'(1))) begin
        cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end
      if (!busy_q[i] && (cnt_q[i] == LAT_W'(1)))
        stray = 1'b1;
    end
    busy_d[0] = 1'b0;
    var_d[0]  = 1'b0;
    cnt_d[0]  = '0;
    for (int unsigned i = 1; i < NREG; i++)
      pending_d = pending_d + CNT_W'(busy_d[i]);
    cmp_bad = cmp_valid & ((cmp_waddr == '0) | !busy_q[cmp_waddr] | !var_q[cmp_waddr]);
    error_d = error_q | cmp_bad | stray;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q    <= '0;
      var_q     <= '0;
      cnt_q     <= '{default: '0};
      pending_q <= '0;
      error_q   <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      var_q     <= var_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      error_q   <= error_d;
    end
  end

  assign busy    = busy_q;
  assign pending = pending_q;
  assign error   = error_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed plan steps then random traffic,
// checked every cycle against an absolute-release-time reference model.
module tb_decode_scoreboard;
  localparam int NREG = 32, IDX_W = 5, LAT_W = 4, MAXOUT = 4, CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             valid = 1'b0, rden1 = 1'b0, rden2 = 1'b0, wren = 1'b0;
  logic [IDX_W-1:0] raddr1 = '0, raddr2 = '0, waddr = '0, cmp_waddr = '0;
  logic             multi = 1'b0, clear = 1'b0, cmp_valid = 1'b0;
  logic [LAT_W-1:0] latency = '0;
  logic             stall, error;
  logic [NREG-1:0]  busy;
  logic [CNT_W-1:0] pending;

  always #5 clock = ~clock;

  decode_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .MAXOUT(MAXOUT)) dut (
    .clock(clock), .reset(reset), .valid(valid),
    .rden1(rden1), .raddr1(raddr1), .rden2(rden2), .raddr2(raddr2),
    .wren(wren), .waddr(waddr), .multi(multi), .latency(latency),
    .clear(clear), .cmp_valid(cmp_valid), .cmp_waddr(cmp_waddr),
    .stall(stall), .busy(busy), .pending(pending), .error(error)
  );

  // Reference model: each busy register holds its absolute release cycle.
  bit m_busy [NREG];
  bit m_var  [NREG];
  int m_due  [NREG];
  bit m_err, m_init;
  int cyc, checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input bit rd1, input int ra1, input bit rd2, input int ra2,
                      input bit we, input int wa, input bit mu, input int lat, input bit clr,
                      input bit cv, input int ca, input bit rst);
    bit rl [NREG];
    bit eff [NREG];
    int np, ne;
    bit exp_stall, iss;
    logic [NREG-1:0] eb;
    @(negedge clock);
    valid = v; rden1 = rd1; raddr1 = IDX_W'(ra1); rden2 = rd2; raddr2 = IDX_W'(ra2);
    wren = we; waddr = IDX_W'(wa); multi = mu; latency = LAT_W'(lat); clear = clr;
    cmp_valid = cv; cmp_waddr = IDX_W'(ca); reset = rst;
    #1;
    np = 0; ne = 0; eb = '0;
    for (int i = 0; i < NREG; i++) begin
      rl[i] = 1'b0;
      if (i > 0 && m_busy[i])
        rl[i] = m_var[i] ? (cv && ca == i) : (m_due[i] == cyc);
      eff[i] = m_busy[i] && !rl[i];
      np += int'(m_busy[i]);
      ne += int'(eff[i]);
      eb[i] = m_busy[i];
    end
    exp_stall = rst && v && ((rd1 && ra1 != 0 && eff[ra1]) || (rd2 && ra2 != 0 && eff[ra2]) ||
                             (we && wa != 0 && eff[wa]) || (mu && we && wa != 0 && ne == MAXOUT));
    chk("stall", 32'(stall), 32'(exp_stall));
    if (m_init) begin
      chk("busy", 32'(busy), 32'(eb));
      chk("pending", 32'(pending), 32'(np));
      chk("error", 32'(error), 32'(m_err));
    end
    iss = v && mu && we && wa != 0 && !exp_stall && !clr;
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin m_busy[i] = 0; m_var[i] = 0; m_due[i] = 0; end
      m_err = 0;
      m_init = 1;
    end else begin
      if (cv && (ca == 0 || !m_busy[ca] || !m_var[ca])) m_err = 1;
      for (int i = 0; i < NREG; i++) if (rl[i]) m_busy[i] = 0;
      if (iss) begin
        m_busy[wa] = 1; m_var[wa] = (lat == 0); m_due[wa] = cyc + lat;
      end
    end
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rst_cycle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int q[$];
    int ca, lat;
    bit cv;
    checks = 0; errors = 0; cyc = 0; m_init = 0; m_err = 0;
    for (int i = 0; i < NREG; i++) begin m_busy[i] = 0; m_var[i] = 0; m_due[i] = 0; end

    rst_cycle(); rst_cycle();
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("idle_stall", 32'(stall), 0);
    chk("idle_busy", 32'(busy), 0);

    // Fixed latency 4 on x3.
    step(1, 0, 0, 0, 0, 1, 3, 1, 4, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("dep_x3_stall", 32'(stall), 1);
    end
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("dep_x3_go", 32'(stall), 0);
    idle();
    chk("x3_freed", 32'(busy[3]), 0);

    // Variable latency on x7.
    step(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 2, 1, 8, 0, 0, 0, 0, 0, 1);
    chk("indep_add", 32'(stall), 0);
    repeat (2) begin
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("dep_x7_stall", 32'(stall), 1);
    end
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1);
    chk("dep_x7_cmp", 32'(stall), 0);
    idle();
    chk("no_error", 32'(error), 0);

    // Latency 1 never stalls a dependent.
    step(1, 0, 0, 0, 0, 1, 4, 1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lat1_busy", 32'(busy[4]), 1);
    chk("lat1_stall", 32'(stall), 0);

    // Outstanding-count cap.
    rst_cycle();
    for (int r = 1; r <= 4; r++) step(1, 0, 0, 0, 0, 1, r, 1, 0, 0, 0, 0, 1);
    idle();
    chk("cap_pending", 32'(pending), 4);
    step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 1);
    chk("cap_stall", 32'(stall), 1);
    step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 1, 2, 1);
    chk("cap_release", 32'(stall), 0);
    idle();
    chk("cap_pending_hold", 32'(pending), 4);
    chk("cap_x5", 32'(busy[5]), 1);
    chk("cap_x2", 32'(busy[2]), 0);
    foreach (q[i]) q.delete(i);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1);

    // Flush blocks new issue but not in-flight work.
    step(1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 9, 1, 2, 1, 0, 0, 1);
    idle();
    chk("clear_x9", 32'(busy[9]), 0);
    idle(); idle();
    chk("clear_x3_freed", 32'(busy[3]), 0);

    // Stray completion and register 0.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 1);
    repeat (2) begin idle(); chk("sticky_error", 32'(error), 1); end
    step(1, 1, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 1);
    chk("x0_write", 32'(stall), 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("x0_busy", 32'(busy[0]), 0);
    chk("x0_read", 32'(stall), 0);

    // Completion arriving after reset dropped the tracking.
    rst_cycle();
    step(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0, 1);
    rst_cycle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1);
    idle();
    chk("late_cmp_error", 32'(error), 1);
    rst_cycle();

    for (int n = 0; n < 3000; n++) begin
      q.delete();
      for (int i = 1; i < NREG; i++) if (m_busy[i] && m_var[i]) q.push_back(i);
      cv = 0; ca = int'($urandom_range(0, 15));
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        cv = 1; ca = q[$urandom_range(0, q.size() - 1)];
      end else if ($urandom_range(0, 59) == 0) begin
        cv = 1;
      end
      lat = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 5));
      step($urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 9)),
           1'($urandom), int'($urandom_range(0, 9)), 1'($urandom),
           int'($urandom_range(0, 9)), 1'($urandom), lat,
           $urandom_range(0, 7) == 0, cv, ca, $urandom_range(0, 149) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
